// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and constants for the APB completer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } apb_state_e;

    localparam logic [1:0]  ALIGN_MASK          = 2'b11;
    localparam logic [31:0] DEFAULT_ID_VALUE    = 32'hA9B0_0001;
    localparam int          DEFAULT_WAIT_STATES = 2;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : apb_regfile
// Description : Word register bank with byte-lane writes; entry 0 is a
//               read-only ID constant.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_regfile #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] i_idx,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_be,
    output logic [DATA_WIDTH-1:0]     o_rdata
);

    localparam int c_idx_w = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

    assign w_regs[0] = ID_VALUE;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (i_wr_en && (i_idx == c_idx_w'(i))) begin
                for (int b = 0; b < DATA_WIDTH/8; b++) begin
                    if (i_be[b]) begin
                        r_q[8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
        end

        assign w_regs[i] = r_q;
    end

    assign o_rdata = w_regs[i_idx];

endmodule : apb_regfile
`default_nettype wire

// File: rtl/apb_completer.sv
`default_nettype none
// ============================================================================
// Module      : apb_completer
// Description : APB completer with programmable wait states, protocol and
//               decode error reporting. APB_COMPLETER_PSTRB_EN enables
//               byte-lane write strobes (otherwise writes replace the word).
// Revision    : 1.0 - initial release
// ============================================================================
module apb_completer
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = DEFAULT_WAIT_STATES,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(DEFAULT_ID_VALUE)
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int                    c_idx_w    = $clog2(NUM_REGS);
    localparam int                    c_cnt_w    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [c_cnt_w-1:0]    c_wait     = c_cnt_w'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-3:0] c_num_regs = (ADDR_WIDTH-2)'(NUM_REGS);

    apb_state_e r_state;
    apb_state_e w_next;

    logic [c_cnt_w-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_strb;

    logic                    w_done;
    logic                    w_abort;
    logic                    w_dec_err;
    logic                    w_wr_en;
    logic [DATA_WIDTH/8-1:0] w_be;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [ADDR_WIDTH-3:0]   w_word;

    assign w_word  = r_addr[ADDR_WIDTH-1:2];
    assign w_done  = (r_state == ACCESS) && (r_cnt == c_wait);
    assign w_abort = !psel || !penable || (paddr != r_addr) || (pwrite != r_write);

    assign w_dec_err = ((r_addr[1:0] & ALIGN_MASK) != 2'b00)
                     || (w_word >= c_num_regs)
                     || (r_write && (w_word == '0))
                     || (!r_write && (r_strb != '0));

    assign w_wr_en = w_done && r_write && !w_dec_err;

`ifdef APB_COMPLETER_PSTRB_EN
    assign w_be = r_strb;
`else
    assign w_be = '1;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && psel && !penable) begin
                r_addr  <= paddr;
                r_write <= pwrite;
                r_wdata <= pwdata;
                r_strb  <= pstrb;
            end
            // Counter restarts on ACCESS entry and holds once it reaches the wait limit
            if ((w_next == ACCESS) && (r_state != ACCESS)) begin
                r_cnt <= '0;
            end else if ((r_state == ACCESS) && (r_cnt != c_wait)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        case (r_state)
            IDLE: begin
                if (psel && !penable) begin
                    w_next = SETUP;
                end else if (psel && penable) begin
                    w_next = ERR;
                end
            end
            SETUP: begin
                w_next = (psel && penable) ? ACCESS : ERR;
            end
            ACCESS: begin
                // Bus changes are only policed while waiting, never on the completion cycle
                if (w_done) begin
                    w_next  = IDLE;
                    pready  = 1'b1;
                    pslverr = w_dec_err;
                    if (!r_write && !w_dec_err) begin
                        prdata = w_rdata;
                    end
                end else if (w_abort) begin
                    w_next = ERR;
                end
            end
            ERR: begin
                w_next  = IDLE;
                pready  = 1'b1;
                pslverr = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    apb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ID_VALUE   (ID_VALUE)
    ) u_regfile (
        .clk     (pclk),
        .rst_n   (presetn),
        .i_wr_en (w_wr_en),
        .i_idx   (r_addr[c_idx_w+1:2]),
        .i_wdata (r_wdata),
        .i_be    (w_be),
        .o_rdata (w_rdata)
    );

endmodule : apb_completer
`default_nettype wire

// File: tb/tb_apb_completer.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_completer
// Description : Directed self-checking bench for apb_completer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_completer;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    // Access-phase cycles seen with pready low: the SETUP-state cycle plus two ACCESS waits
    localparam int EXP_WAITS = 3;

`ifdef APB_COMPLETER_PSTRB_EN
    localparam logic [31:0] EXP_STRB_WORD = 32'hAA22_CC44;
`else
    localparam logic [31:0] EXP_STRB_WORD = 32'h1122_3344;
`endif

    always #5 pclk = ~pclk;

    apb_completer dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rdata,
                        output logic err, output int waits);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge pclk);
        penable = 1'b1;
        waits = 0;
        #1;
        while (!pready && waits < 20) begin
            waits++;
            @(negedge pclk);
            #1;
        end
        rdata = prdata;
        err   = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        int          w;
        xfer(1'b1, addr, data, strb, rd, err, w);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_waits"}, w, EXP_WAITS);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        int          w;
        xfer(1'b0, addr, 32'h0, strb, rd, err, w);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_waits"}, w, EXP_WAITS);
    endtask

    initial begin
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(negedge pclk);
        #1;
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        @(negedge pclk);
        presetn = 1'b1;

        do_write("wr4", 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b0);
        do_read("rd4", 32'h4, 4'h0, 32'hDEAD_BEEF, 1'b0);
        do_read("rd3", 32'h3, 4'h0, 32'h0, 1'b1);
        do_read("rd0", 32'h0, 4'h0, 32'hA9B0_0001, 1'b0);

        // Abort: psel drops during the second ACCESS cycle of a write to 0x8
        do_write("wr8", 32'h8, 32'hAABB_CCDD, 4'hF, 1'b0);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h1234_5678; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        psel = 1'b0;
        #1;
        check("abort_wait_pready", {31'd0, pready}, 32'd0);
        @(negedge pclk);
        #1;
        check("abort_err_pready", {31'd0, pready}, 32'd1);
        check("abort_err_pslverr", {31'd0, pslverr}, 32'd1);
        check("abort_err_prdata", prdata, 32'd0);
        @(negedge pclk);
        penable = 1'b0;
        #1;
        check("abort_after_pready", {31'd0, pready}, 32'd0);
        check("abort_after_pslverr", {31'd0, pslverr}, 32'd0);
        do_read("rd8_kept", 32'h8, 4'h0, 32'hAABB_CCDD, 1'b0);

        do_write("wr8_strb", 32'h8, 32'h1122_3344, 4'h5, 1'b0);
        do_read("rd8_strb", 32'h8, 4'h0, EXP_STRB_WORD, 1'b0);

        do_write("wr40", 32'h40, 32'h5555_5555, 4'hF, 1'b1);
        do_write("wr0", 32'h0, 32'h1234_5678, 4'hF, 1'b1);
        do_read("rd0_kept", 32'h0, 4'h0, 32'hA9B0_0001, 1'b0);
        do_read("rd4_strb", 32'h4, 4'h1, 32'h0, 1'b1);

        // Access phase straight from IDLE is a protocol error
        @(negedge pclk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h4; pstrb = 4'h0;
        @(negedge pclk);
        #1;
        check("idle_err_pready", {31'd0, pready}, 32'd1);
        check("idle_err_pslverr", {31'd0, pslverr}, 32'd1);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        #1;
        check("idle_err_clear", {31'd0, pready}, 32'd0);

        // Reset asserted in the completion cycle of a write to 0xC
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h0000_0055; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        repeat (3) @(negedge pclk);
        #1;
        check("rst_mid_pready_before", {31'd0, pready}, 32'd1);
        presetn = 1'b0;
        #1;
        check("rst_mid_pready", {31'd0, pready}, 32'd0);
        check("rst_mid_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_mid_prdata", prdata, 32'd0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge pclk);
        presetn = 1'b1;

        do_read("post_rst_id", 32'h0, 4'h0, 32'hA9B0_0001, 1'b0);
        for (int i = 1; i < 16; i++) begin
            do_read($sformatf("post_rst_r%0d", i), 32'(i * 4), 4'h0, 32'h0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_apb_completer
`default_nettype wire

// File: doc/apb_completer.md
APB_COMPLETER -- requirements
Module: apb_completer

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; NUM_REGS, 16, word registers; WAIT_STATES, 2, ACCESS cycles before pready; ID_VALUE, 32'hA9B0_0001, register 0 contents.
REQ-002 SHALL have ports: pclk  in  1  clock; presetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: psel  in  1  select; penable  in  1  access phase; pwrite  in  1  1=write.
REQ-004 SHALL have ports: paddr  in  ADDR_WIDTH  byte address; pwdata  in  DATA_WIDTH  write data; pstrb  in  DATA_WIDTH/8  byte-lane strobes.
REQ-005 SHALL have ports: prdata  out  DATA_WIDTH  read data; pready  out  1  transfer complete; pslverr  out  1  transfer error.

Function
REQ-006 SHALL implement an FSM with states IDLE, SETUP, ACCESS and ERR, all on posedge pclk.
REQ-007 IDLE: psel&!penable -> SETUP, latching paddr, pwrite, pwdata and pstrb; psel&penable -> ERR; otherwise stay.
REQ-008 SETUP -> ACCESS when psel&penable; otherwise -> ERR; on entering ACCESS the wait counter SHALL clear to 0.
REQ-009 ACCESS: the counter SHALL increment each cycle, saturating at WAIT_STATES; pready SHALL be 1 only when count==WAIT_STATES (WAIT_STATES=0 gives a zero-wait transfer).
REQ-010 ACCESS SHALL go -> ERR before completion if psel=0, penable=0, or paddr/pwrite differ from the latched values.
REQ-011 ERR SHALL assert pready=1 and pslverr=1 for exactly one cycle, perform no register write, then go -> IDLE.
REQ-012 Completion cycle (ACCESS with pready=1) SHALL go -> IDLE; a new SETUP SHALL be accepted on the following cycle.
REQ-013 Completion SHALL set pslverr=1 if paddr[1:0]!=0, word index >= NUM_REGS, a write targets register 0, or a read has pstrb!=0.
REQ-014 Successful write SHALL update the register on the completion edge; an errored transfer SHALL leave all registers unchanged.
REQ-015 Read SHALL drive prdata with the register value during the completion cycle; register 0 SHALL return ID_VALUE; prdata SHALL be 0 in all other cycles and on error.
REQ-016 pready and pslverr SHALL be 0 outside completion and ERR cycles.

Reset
REQ-017 presetn=0 SHALL asynchronously force state=IDLE, counter=0, registers 1..NUM_REGS-1=0, pready=0, pslverr=0, prdata=0.
REQ-018 Reset during SETUP/ACCESS SHALL abort the transfer with no register write; operation SHALL resume from IDLE on the first edge after deassertion.

Configuration
REQ-019 Macro APB_COMPLETER_PSTRB_EN defined: writes SHALL update only byte lanes with pstrb[i]=1; pstrb=0 SHALL complete without error and without change.
REQ-020 APB_COMPLETER_PSTRB_EN undefined: writes SHALL replace the full word regardless of pstrb; the read pstrb!=0 error check SHALL still apply.

Structure
REQ-021 Package apb_pkg SHALL hold the state enum (apb_state_e), ALIGN_MASK, and the default ID_VALUE and WAIT_STATES constants.
REQ-022 SHALL instantiate one sub-module, apb_regfile, containing register storage, byte-lane write and read mux; the FSM and error decode SHALL remain in apb_completer.

Verification
REQ-023 Write 32'hDEADBEEF to 0x4 with pstrb=4'hF, then read 0x4 -> prdata=32'hDEADBEEF, pslverr=0, pready after exactly 2 ACCESS wait cycles.
REQ-024 Read from 0x3 -> completion with pslverr=1 and prdata=0; the next read of 0x0 SHALL return prdata=32'hA9B0_0001.
REQ-025 Drop psel one cycle into ACCESS of a write to 0x8 -> one ERR cycle with pready=1 and pslverr=1; 0x8 is unchanged.
REQ-026 Reg 0x8 holds 32'hAABBCCDD; write 32'h11223344 with pstrb=4'h5 -> readback 32'hAA22CC44 with APB_COMPLETER_PSTRB_EN, 32'h11223344 without.
REQ-027 Write to 0x40 -> pslverr=1; write to 0x0 -> pslverr=1 with ID unchanged; read with pstrb=4'h1 -> pslverr=1.
REQ-028 Assert presetn=0 mid-ACCESS of a write -> pready, pslverr and prdata go to 0 immediately; all registers read back 0 after reset.
